ipf_res_buf: RTL and testbench

IPF_RES_BUF -- requirements
Module: ipf_res_buf

---
 rtl/ipf_pkg.sv | 16 +
 rtl/ipf_res_ram.sv | 28 ++
 rtl/ipf_res_buf.sv | 185 ++++++++++++++++++
 tb/tb_ipf_res_buf.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipf_pkg.sv
// Shared definitions for the result buffer: the buffer state encoding and
// the default geometry (result width, channels per word, word depth).
package ipf_pkg;

  localparam int unsigned RES_W_DEF = 1152;
  localparam int unsigned NCH_DEF   = 128;
  localparam int unsigned DEPTH_DEF = 128;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_FULL  = 2'd2,
    ST_WRAP  = 2'd3
  } buf_state_e;

endpackage

// File: rtl/ipf_res_ram.sv
// Simple dual-port result storage: one write port and one registered read port.
// A read and a write to the same address in one cycle return the old contents.
module ipf_res_ram #(
  parameter int W     = 1152,
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  // Non-blocking write and read in the same block give read-before-write.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ipf_res_buf.sv
// Result capture buffer with stop-on-full or wrap modes, registered word and
// channel read-out, and occupancy flags.
// Optional write-time comparison against expected data: IPF_RESBUF_CMP_EN.
module ipf_res_buf
  import ipf_pkg::*;
#(
  parameter int RES_W = RES_W_DEF,
  parameter int NCH   = NCH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int CH_W = RES_W / NCH,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             mode,
  input  logic             res_valid,
  input  logic [RES_W-1:0] res,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  input  logic [CW-1:0]    rd_ch,
`ifdef IPF_RESBUF_CMP_EN
  input  logic [RES_W-1:0] exp_data,
  output logic [15:0]      err_cnt,
  output logic [AW-1:0]    first_err,
  output logic             err_flag,
`endif
  output logic             rd_valid,
  output logic [RES_W-1:0] rd_data,
  output logic [CH_W-1:0]  rd_ch_data,
  output logic             rd_err,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic [1:0]       state
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]    count_q, count_d;
  buf_state_e     state_q, state_d;
  logic           ovf_q, ovf_d;
  logic           rd_valid_q, rd_valid_d;
  logic           rd_err_q, rd_err_d;
  logic [CW-1:0]  rd_ch_q, rd_ch_d;
  logic           full_w;
  logic           wr_acc;
  logic [RES_W-1:0] ram_rdata;

  assign full_w = (count_q == DEPTH_C);
  // A write lands in memory unless clr wins or the buffer is full in stop mode.
  assign wr_acc = res_valid && !clr && (!full_w || mode);

  // Next-state for pointers, occupancy, buffer state and the overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    ovf_d    = ovf_q;
    if (clr) begin
      wr_ptr_d = '0;
      count_d  = '0;
      state_d  = ST_EMPTY;
      ovf_d    = 1'b0;
    end else if (res_valid) begin
      if (full_w) begin
        ovf_d = 1'b1;
        if (mode) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          state_d  = ST_WRAP;
        end
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        count_d  = count_q + 1'b1;
        state_d  = (count_q + 1'b1 == DEPTH_C) ? ST_FULL : ST_FILL;
      end
    end
  end

  // Read request bookkeeping; unwritten addresses only exist before the buffer fills.
  always_comb begin
    rd_valid_d = rd_en;
    rd_err_d   = rd_en && (state_q != ST_FULL) && (state_q != ST_WRAP)
                 && ({1'b0, rd_addr} >= count_q);
    rd_ch_d    = rd_en ? rd_ch : rd_ch_q;
  end

  // Control and read-path registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= ST_EMPTY;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_ch_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      rd_ch_q    <= rd_ch_d;
    end
  end

  ipf_res_ram #(
    .W     (RES_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (res),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

  // The memory output register is never reset, so gate it with the read flags.
  assign rd_data = (rd_valid_q && !rd_err_q) ? ram_rdata : '0;

  logic [CH_W-1:0] ch_arr [NCH];
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign ch_arr[gi] = rd_data[gi*CH_W +: CH_W];
  end
  assign rd_ch_data = ch_arr[rd_ch_q];

  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;
  assign count    = count_q;
  assign full     = full_w;
  assign empty    = (count_q == '0);
  assign ovf      = ovf_q;
  assign state    = state_q;

`ifdef IPF_RESBUF_CMP_EN
  logic [15:0]   err_cnt_q, err_cnt_d;
  logic [AW-1:0] first_err_q, first_err_d;
  logic          err_flag_q, err_flag_d;
  logic          mismatch;

  assign mismatch = wr_acc && (res != exp_data);

  // Mismatch tracking: saturating count, sticky flag, address of the first miss.
  always_comb begin
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    err_flag_d  = err_flag_q;
    if (clr) begin
      err_cnt_d   = '0;
      first_err_d = '0;
      err_flag_d  = 1'b0;
    end else if (mismatch) begin
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      if (!err_flag_q) first_err_d = wr_ptr_q;
      err_flag_d = 1'b1;
    end
  end

  // Compare result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt_q   <= '0;
      first_err_q <= '0;
      err_flag_q  <= 1'b0;
    end else begin
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      err_flag_q  <= err_flag_d;
    end
  end

  assign err_cnt   = err_cnt_q;
  assign first_err = first_err_q;
  assign err_flag  = err_flag_q;
`endif

endmodule

// File: tb/tb_ipf_res_buf.sv
// Directed bench for ipf_res_buf at default geometry (1152-bit words, 128 x 9-bit channels, depth 128).
module tb_ipf_res_buf;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr = 1'b0;
  logic          mode = 1'b0;
  logic          res_valid = 1'b0;
  logic [1151:0] res = '0;
  logic          rd_en = 1'b0;
  logic [6:0]    rd_addr = '0;
  logic [6:0]    rd_ch = '0;
  logic          rd_valid;
  logic [1151:0] rd_data;
  logic [8:0]    rd_ch_data;
  logic          rd_err;
  logic [7:0]    count;
  logic          full, empty, ovf;
  logic [1:0]    state;
`ifdef IPF_RESBUF_CMP_EN
  logic [1151:0] exp_data = '0;
  logic [15:0]   err_cnt;
  logic [6:0]    first_err;
  logic          err_flag;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ipf_res_buf dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .mode       (mode),
    .res_valid  (res_valid),
    .res        (res),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_ch      (rd_ch),
`ifdef IPF_RESBUF_CMP_EN
    .exp_data   (exp_data),
    .err_cnt    (err_cnt),
    .first_err  (first_err),
    .err_flag   (err_flag),
`endif
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_ch_data (rd_ch_data),
    .rd_err     (rd_err),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .ovf        (ovf),
    .state      (state)
  );

  function automatic logic [1151:0] pat(input logic [7:0] b);
    return {144{b}};
  endfunction

  task automatic check(input string tag, input logic [1151:0] obs, input logic [1151:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_res(input logic [1151:0] w);
    res = w;
`ifdef IPF_RESBUF_CMP_EN
    exp_data = w;
`endif
  endtask

  task automatic wr(input logic [1151:0] w);
    @(negedge clk);
    res_valid = 1'b1;
    set_res(w);
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  task automatic rd(input logic [6:0] a, input logic [6:0] c);
    @(negedge clk);
    rd_en = 1'b1;
    rd_addr = a;
    rd_ch = c;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ovf", ovf, 0);
    check("rst_state", state, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_err", rd_err, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_ch_data", rd_ch_data, 0);
    rst = 1'b1;

    // Fill with word k = byte k repeated
    for (int k = 0; k < 128; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("fill1_state", state, 1);
        check("fill1_count", count, 1);
      end
      res_valid = 1'b1;
      set_res(pat(k[7:0]));
    end
    @(negedge clk);
    res_valid = 1'b0;
    $display("filled 128 words");
    check("full_count", count, 128);
    check("full_full", full, 1);
    check("full_empty", empty, 0);
    check("full_state", state, 2);
    check("full_ovf", ovf, 0);

    // Word 5, channel 3: bits 27..35 of 0x05 repeated -> bits 32,34 set -> 0x0A0
    rd(7'd5, 7'd3);
    $display("read addr 5 ch 3");
    check("rd5_valid", rd_valid, 1);
    check("rd5_data", rd_data, pat(8'd5));
    check("rd5_ch3", rd_ch_data, 9'h0A0);
    check("rd5_err", rd_err, 0);
    @(negedge clk);
    check("rd5_valid_drop", rd_valid, 0);

    // Stop mode: write while full is dropped
    mode = 1'b0;
    wr(pat(8'hAA));
    $display("stop-mode write 0xAA while full");
    check("stop_ovf", ovf, 1);
    check("stop_count", count, 128);
    check("stop_state", state, 2);
    rd(7'd0, 7'd0);
    check("stop_addr0", rd_data, pat(8'd0));
    check("stop_addr0_err", rd_err, 0);
    rd(7'd127, 7'd0);
    check("stop_addr127", rd_data, pat(8'd127));

    // Wrap mode: three overwrites at 0..2
    mode = 1'b1;
    wr(pat(8'd200));
    wr(pat(8'd201));
    wr(pat(8'd202));
    $display("wrap-mode 3 writes");
    check("wrap_state", state, 3);
    check("wrap_count", count, 128);
    check("wrap_ovf", ovf, 1);
    check("wrap_wr_ptr", dut.wr_ptr_q, 3);
    rd(7'd0, 7'd0);
    check("wrap_addr0", rd_data, pat(8'd200));
    rd(7'd2, 7'd0);
    check("wrap_addr2", rd_data, pat(8'd202));
    check("wrap_addr2_ch0", rd_ch_data, 9'h0CA);
    rd(7'd3, 7'd0);
    check("wrap_addr3", rd_data, pat(8'd3));

    // Same-address read and write: old contents returned
    @(negedge clk);
    res_valid = 1'b1;
    set_res(pat(8'd77));
    rd_en = 1'b1;
    rd_addr = 7'd3;
    rd_ch = 7'd0;
    @(negedge clk);
    res_valid = 1'b0;
    rd_en = 1'b0;
    $display("read/write collision at addr 3");
    check("rbw_old", rd_data, pat(8'd3));
    rd(7'd3, 7'd0);
    check("rbw_new", rd_data, pat(8'd77));

    // clr with res_valid: clr wins
    @(negedge clk);
    clr = 1'b1;
    res_valid = 1'b1;
    set_res(pat(8'd99));
    @(negedge clk);
    clr = 1'b0;
    res_valid = 1'b0;
    mode = 1'b0;
    $display("clr with res_valid");
    check("clr_count", count, 0);
    check("clr_empty", empty, 1);
    check("clr_state", state, 0);
    check("clr_ovf", ovf, 0);
    check("clr_wr_ptr", dut.wr_ptr_q, 0);

    // Read of unwritten address while empty
    rd(7'd10, 7'd0);
    $display("empty read addr 10");
    check("err_valid", rd_valid, 1);
    check("err_rd_err", rd_err, 1);
    check("err_data", rd_data, 0);
    check("err_ch_data", rd_ch_data, 0);
    @(negedge clk);
    check("err_pulse_drop", rd_err, 0);

`ifdef IPF_RESBUF_CMP_EN
    // Compare: mismatches at write addresses 4 and 7
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      res_valid = 1'b1;
      res = pat(k[7:0]);
      exp_data = (k == 4 || k == 7) ? ~pat(k[7:0]) : pat(k[7:0]);
    end
    @(negedge clk);
    res_valid = 1'b0;
    $display("compare 10 writes");
    check("cmp_err_cnt", err_cnt, 2);
    check("cmp_first_err", first_err, 4);
    check("cmp_err_flag", err_flag, 1);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("cmp_clr_cnt", err_cnt, 0);
    check("cmp_clr_flag", err_flag, 0);
`endif

    // Reset during a write burst with a read in flight
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      res_valid = 1'b1;
      set_res(pat(8'(k + 50)));
      if (k == 39) begin
        rd_en = 1'b1;
        rd_addr = 7'd0;
      end
    end
    @(negedge clk);
    $display("burst of 40 then reset");
    check("burst_count", count, 40);
    check("burst_rd_valid", rd_valid, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_rd_valid", rd_valid, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_state", state, 0);
    check("mid_rst_empty", empty, 1);
    @(negedge clk);
    rst = 1'b1;
    res_valid = 1'b0;
    rd_en = 1'b0;
    wr(pat(8'd33));
    rd(7'd0, 7'd0);
    $display("post-reset write/read addr 0");
    check("post_rst_addr0", rd_data, pat(8'd33));
    check("post_rst_count", count, 1);
    check("post_rst_state", state, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
